// File: rtl/pulse_cfg_loader_pkg.sv
// Shared definitions for the pulse-sequence config loader: address map,
// per-address byte counts, reset values and parser state encodings.
package pulse_cfg_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF      = 8'hA5;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 50000;
  localparam int unsigned TO_W_DEF           = 16;

  localparam logic [7:0] ADDR_PER    = 8'h00;
  localparam logic [7:0] ADDR_P1WID  = 8'h01;
  localparam logic [7:0] ADDR_DEL    = 8'h02;
  localparam logic [7:0] ADDR_P2WID  = 8'h03;
  localparam logic [7:0] ADDR_NUT_W  = 8'h04;
  localparam logic [7:0] ADDR_NUT_D  = 8'h05;
  localparam logic [7:0] ADDR_CP     = 8'h06;
  localparam logic [7:0] ADDR_P_BL   = 8'h07;
  localparam logic [7:0] ADDR_BL     = 8'h08;
  localparam logic [7:0] ADDR_COMMIT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CSUM
  } parse_state_t;

  typedef struct packed {
    logic [31:0] per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [7:0]  nut_w;
    logic [15:0] nut_d;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_hf;
    logic        bl;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{
    per:     32'd4000,
    p1wid:   16'd30,
    del:     16'd200,
    p2wid:   16'd60,
    nut_w:   8'd0,
    nut_d:   16'd0,
    cp:      8'd1,
    p_bl:    8'd100,
    p_bl_hf: 16'd50,
    bl:      1'b1
  };

  // Returns {valid, data byte count}; COMMIT is valid with zero data bytes.
  function automatic logic [3:0] addr_len(input logic [7:0] addr);
    case (addr)
      ADDR_PER:                                  return 4'b1_100;
      ADDR_P1WID, ADDR_DEL, ADDR_P2WID,
      ADDR_NUT_D:                                return 4'b1_010;
      ADDR_NUT_W, ADDR_CP, ADDR_P_BL, ADDR_BL:   return 4'b1_001;
      ADDR_COMMIT:                               return 4'b1_000;
      default:                                   return 4'b0_000;
    endcase
  endfunction

endpackage

// File: rtl/pulse_cfg_loader_if.sv
// Received-byte stream from the UART RX into the config loader.
interface pulse_cfg_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/pulse_cfg_loader_frame_parser.sv
// Frame parser: sync/addr/data/checksum FSM, byte assembly and inter-byte timeout.
module pulse_cfg_loader_frame_parser
  import pulse_cfg_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned TO_W           = TO_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  pulse_cfg_loader_if.slave   rx,
  output logic                wr_en,
  output logic [7:0]          wr_addr,
  output logic [31:0]         wr_data,
  output logic                commit_req,
  output logic                frame_err
);
  // state   | meaning
  // IDLE    | hunting for SYNC_BYTE, other bytes dropped
  // ADDR    | next byte is the register address
  // DATA    | collecting data bytes MSB first
  // CSUM    | next byte is XOR of address and data

  parse_state_t      state_q, state_d;
  logic [7:0]        addr_q, addr_d;
  logic [31:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [TO_W-1:0]   to_cnt_q;
  logic              err_d, timeout;
  logic [3:0]        alen;

  assign alen    = addr_len(rx.rx_data);
  assign wr_addr = addr_q;
  assign wr_data = asm_q;
  assign timeout = (state_q != ST_IDLE) && !rx.rx_valid &&
                   (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      asm_q     <= '0;
      csum_q    <= '0;
      cnt_q     <= '0;
      to_cnt_q  <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      asm_q     <= asm_d;
      csum_q    <= csum_d;
      cnt_q     <= cnt_d;
      frame_err <= err_d;
      if (state_d == ST_IDLE || rx.rx_valid) to_cnt_q <= '0;
      else                                   to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    wr_en      = 1'b0;
    commit_req = 1'b0;
    if (timeout) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else if (rx.rx_valid) begin
      case (state_q)
        ST_IDLE: if (rx.rx_data == SYNC_BYTE) state_d = ST_ADDR;
        ST_ADDR: begin
          addr_d = rx.rx_data;
          csum_d = rx.rx_data;
          asm_d  = '0;
          if (!alen[3]) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (alen[2:0] == 3'd0) begin
            state_d = ST_CSUM;
          end else begin
            cnt_d   = alen[2:0];
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          asm_d  = {asm_q[23:0], rx.rx_data};
          csum_d = csum_q ^ rx.rx_data;
          cnt_d  = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          state_d = ST_IDLE;
          if (rx.rx_data != csum_q)       err_d      = 1'b1;
          else if (addr_q == ADDR_COMMIT) commit_req = 1'b1;
          else                            wr_en      = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pulse_cfg_loader.sv
// Pulse-sequence config loader: shadow bank filled from UART frames, committed
// to the active bank only on a period_start boundary.
module pulse_cfg_loader
  import pulse_cfg_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned TO_W           = TO_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  pulse_cfg_loader_if.slave   rx,
  input  logic                period_start,
  output logic [31:0]         per,
  output logic [15:0]         p1wid,
  output logic [15:0]         del,
  output logic [15:0]         p2wid,
  output logic [7:0]          nut_w,
  output logic [15:0]         nut_d,
  output logic [7:0]          cp,
  output logic [7:0]          p_bl,
  output logic [15:0]         p_bl_hf,
  output logic                bl,
  output logic                cfg_update,
  output logic                commit_pend,
  output logic                frame_err
);

  logic        wr_en, commit_req;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  cfg_t        shadow_q, active_q, commit_val;

  pulse_cfg_loader_frame_parser #(
    .SYNC_BYTE      (SYNC_BYTE),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_parser (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit_req (commit_req),
    .frame_err  (frame_err)
  );

  always_comb begin
    commit_val         = shadow_q;
    commit_val.p_bl_hf = {8'd0, shadow_q.p_bl} >> 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= CFG_DEFAULT;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_PER:   shadow_q.per   <= wr_data;
        ADDR_P1WID: shadow_q.p1wid <= wr_data[15:0];
        ADDR_DEL:   shadow_q.del   <= wr_data[15:0];
        ADDR_P2WID: shadow_q.p2wid <= wr_data[15:0];
        ADDR_NUT_W: shadow_q.nut_w <= wr_data[7:0];
        ADDR_NUT_D: shadow_q.nut_d <= wr_data[15:0];
        ADDR_CP:    shadow_q.cp    <= wr_data[7:0];
        ADDR_P_BL:  shadow_q.p_bl  <= wr_data[7:0];
        ADDR_BL:    shadow_q.bl    <= wr_data[0];
        default:    ;
      endcase
    end
  end

  // A commit request arriving on the same edge as the commit re-arms the flag,
  // so it is applied at the following period_start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q    <= CFG_DEFAULT;
      cfg_update  <= 1'b0;
      commit_pend <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      if (period_start && commit_pend) begin
        active_q    <= commit_val;
        cfg_update  <= 1'b1;
        commit_pend <= 1'b0;
      end
      if (commit_req) commit_pend <= 1'b1;
    end
  end

  assign per     = active_q.per;
  assign p1wid   = active_q.p1wid;
  assign del     = active_q.del;
  assign p2wid   = active_q.p2wid;
  assign nut_w   = active_q.nut_w;
  assign nut_d   = active_q.nut_d;
  assign cp      = active_q.cp;
  assign p_bl    = active_q.p_bl;
  assign p_bl_hf = active_q.p_bl_hf;
  assign bl      = active_q.bl;

endmodule
